// File: rtl/tl_width_coupler_if.sv
// Wide-side A/D and narrow-side A/D channel bundle for the TileLink width coupler.
// The slave modport is the coupler's view; master is the surrounding fabric's view.
interface tl_width_coupler_if #(
  parameter int IN_BYTES    = 16,
  parameter int OUT_BYTES   = 8,
  parameter int ADDR_BITS   = 32,
  parameter int SOURCE_BITS = 6,
  parameter int SINK_BITS   = 4,
  parameter int SIZE_BITS   = 3
);
  // Wide A (into the coupler)
  logic                   auto_in_a_valid;
  logic                   auto_in_a_ready;
  logic [2:0]             auto_in_a_bits_opcode;
  logic [2:0]             auto_in_a_bits_param;
  logic [SIZE_BITS-1:0]   auto_in_a_bits_size;
  logic [SOURCE_BITS-1:0] auto_in_a_bits_source;
  logic [ADDR_BITS-1:0]   auto_in_a_bits_address;
  logic [IN_BYTES-1:0]    auto_in_a_bits_mask;
  logic [8*IN_BYTES-1:0]  auto_in_a_bits_data;
  logic                   auto_in_a_bits_corrupt;

  // Narrow A (out of the coupler)
  logic                   auto_out_a_valid;
  logic                   auto_out_a_ready;
  logic [2:0]             auto_out_a_bits_opcode;
  logic [2:0]             auto_out_a_bits_param;
  logic [SIZE_BITS-1:0]   auto_out_a_bits_size;
  logic [SOURCE_BITS-1:0] auto_out_a_bits_source;
  logic [ADDR_BITS-1:0]   auto_out_a_bits_address;
  logic [OUT_BYTES-1:0]   auto_out_a_bits_mask;
  logic [8*OUT_BYTES-1:0] auto_out_a_bits_data;
  logic                   auto_out_a_bits_corrupt;

  // Narrow D (into the coupler)
  logic                   auto_out_d_valid;
  logic                   auto_out_d_ready;
  logic [2:0]             auto_out_d_bits_opcode;
  logic [1:0]             auto_out_d_bits_param;
  logic [SIZE_BITS-1:0]   auto_out_d_bits_size;
  logic [SOURCE_BITS-1:0] auto_out_d_bits_source;
  logic [SINK_BITS-1:0]   auto_out_d_bits_sink;
  logic                   auto_out_d_bits_denied;
  logic [8*OUT_BYTES-1:0] auto_out_d_bits_data;
  logic                   auto_out_d_bits_corrupt;

  // Wide D (out of the coupler)
  logic                   auto_in_d_valid;
  logic                   auto_in_d_ready;
  logic [2:0]             auto_in_d_bits_opcode;
  logic [1:0]             auto_in_d_bits_param;
  logic [SIZE_BITS-1:0]   auto_in_d_bits_size;
  logic [SOURCE_BITS-1:0] auto_in_d_bits_source;
  logic [SINK_BITS-1:0]   auto_in_d_bits_sink;
  logic                   auto_in_d_bits_denied;
  logic [8*IN_BYTES-1:0]  auto_in_d_bits_data;
  logic                   auto_in_d_bits_corrupt;

  modport slave (
    input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt,
    output auto_in_a_ready,
    output auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt,
    input  auto_out_a_ready,
    input  auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
           auto_out_d_bits_data, auto_out_d_bits_corrupt,
    output auto_out_d_ready,
    output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt,
    input  auto_in_d_ready
  );

  modport master (
    output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param, auto_in_a_bits_size,
           auto_in_a_bits_source, auto_in_a_bits_address, auto_in_a_bits_mask,
           auto_in_a_bits_data, auto_in_a_bits_corrupt,
    input  auto_in_a_ready,
    input  auto_out_a_valid, auto_out_a_bits_opcode, auto_out_a_bits_param, auto_out_a_bits_size,
           auto_out_a_bits_source, auto_out_a_bits_address, auto_out_a_bits_mask,
           auto_out_a_bits_data, auto_out_a_bits_corrupt,
    output auto_out_a_ready,
    output auto_out_d_valid, auto_out_d_bits_opcode, auto_out_d_bits_param, auto_out_d_bits_size,
           auto_out_d_bits_source, auto_out_d_bits_sink, auto_out_d_bits_denied,
           auto_out_d_bits_data, auto_out_d_bits_corrupt,
    input  auto_out_d_ready,
    input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_param, auto_in_d_bits_size,
           auto_in_d_bits_source, auto_in_d_bits_sink, auto_in_d_bits_denied,
           auto_in_d_bits_data, auto_in_d_bits_corrupt,
    output auto_in_d_ready
  );
endinterface

// File: rtl/tl_width_coupler.sv
// TileLink-UH wide-to-narrow width adapter: splits wide A beats into narrow lanes
// and gathers narrow D beats back into wide beats with sticky denied/corrupt.
module tl_width_coupler #(
  parameter int IN_BYTES    = 16,
  parameter int OUT_BYTES   = 8,
  parameter int ADDR_BITS   = 32,
  parameter int SOURCE_BITS = 6,
  parameter int SINK_BITS   = 4,
  parameter int SIZE_BITS   = 3
) (
  input  logic               clock,
  input  logic               reset,
  tl_width_coupler_if.slave  bus
);
  localparam int RATIO  = IN_BYTES / OUT_BYTES;
  localparam int RB     = $clog2(RATIO);
  localparam int LB     = $clog2(OUT_BYTES);
  localparam int WB     = $clog2(IN_BYTES);
  localparam int LANE_W = 8 * OUT_BYTES;

  typedef logic [RB-1:0] idx_t;
  typedef logic [RB:0]   cnt_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [2:0]             param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [ADDR_BITS-1:0]   address;
    logic                   corrupt;
  } a_hdr_t;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [SIZE_BITS-1:0]   size;
    logic [SOURCE_BITS-1:0] source;
    logic [SINK_BITS-1:0]   sink;
  } d_hdr_t;

  // Narrow beats per wide beat: 2^(size-LB) clamped to [1, RATIO]; data-less messages take one.
  function automatic cnt_t beats_of(input logic has_data, input logic [SIZE_BITS-1:0] size);
    int sh;
    sh = int'(size) - LB;
    if (!has_data || sh < 0) sh = 0;
    if (sh > RB) sh = RB;
    return cnt_t'(1) << sh;
  endfunction

  // ---------------- A path ----------------
  a_hdr_t            a_hdr;
  logic              a_has_data;
  cnt_t              a_beats;
  idx_t              a_last_idx;
  idx_t              a_base;
  idx_t              a_lane;
  idx_t              a_idx_q, a_idx_d;
  logic              a_last;
  logic              a_fire;
  logic [LANE_W-1:0]    a_data_lanes [RATIO];
  logic [OUT_BYTES-1:0] a_mask_lanes [RATIO];

  assign a_hdr = {bus.auto_in_a_bits_opcode, bus.auto_in_a_bits_param, bus.auto_in_a_bits_size,
                  bus.auto_in_a_bits_source, bus.auto_in_a_bits_address, bus.auto_in_a_bits_corrupt};

  assign a_has_data = ~a_hdr.opcode[2];
  assign a_beats    = beats_of(a_has_data, a_hdr.size);
  assign a_last_idx = idx_t'(a_beats - cnt_t'(1));
  // Sub-beat transfers start at the lane their address selects; full-width ones start at lane 0.
  assign a_base     = (int'(a_hdr.size) < WB) ? a_hdr.address[WB-1:LB] : '0;
  assign a_lane     = a_base + a_idx_q;
  assign a_last     = (a_idx_q == a_last_idx);
  assign a_fire     = bus.auto_out_a_valid & bus.auto_out_a_ready;

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_a_lanes
      assign a_data_lanes[gi] = bus.auto_in_a_bits_data[gi*LANE_W +: LANE_W];
      assign a_mask_lanes[gi] = bus.auto_in_a_bits_mask[gi*OUT_BYTES +: OUT_BYTES];
    end
  endgenerate

  assign bus.auto_out_a_valid        = bus.auto_in_a_valid;
  assign bus.auto_in_a_ready         = bus.auto_out_a_ready & a_last;
  assign bus.auto_out_a_bits_opcode  = a_hdr.opcode;
  assign bus.auto_out_a_bits_param   = a_hdr.param;
  assign bus.auto_out_a_bits_size    = a_hdr.size;
  assign bus.auto_out_a_bits_source  = a_hdr.source;
  assign bus.auto_out_a_bits_address = a_hdr.address;
  assign bus.auto_out_a_bits_corrupt = a_hdr.corrupt;
  assign bus.auto_out_a_bits_data    = a_data_lanes[a_lane];
  assign bus.auto_out_a_bits_mask    = a_mask_lanes[a_lane];

  always_comb begin
    a_idx_d = a_idx_q;
    if (a_fire) a_idx_d = a_last ? '0 : a_idx_q + idx_t'(1);
  end

  // ---------------- D path ----------------
  d_hdr_t            d_hdr;
  logic              d_has_data;
  cnt_t              d_beats;
  idx_t              d_last_idx;
  logic              d_last;
  logic              d_fire;
  idx_t              d_cnt_q, d_cnt_d;
  logic              d_denied_q, d_denied_d;
  logic              d_corrupt_q, d_corrupt_d;
  logic              d_store;
  logic [LANE_W-1:0] d_buf_q [RATIO];
  idx_t              d_sel   [RATIO];

  assign d_hdr = {bus.auto_out_d_bits_opcode, bus.auto_out_d_bits_param, bus.auto_out_d_bits_size,
                  bus.auto_out_d_bits_source, bus.auto_out_d_bits_sink};

  assign d_has_data = (d_hdr.opcode == 3'd1) || (d_hdr.opcode == 3'd5);
  assign d_beats    = beats_of(d_has_data, d_hdr.size);
  assign d_last_idx = idx_t'(d_beats - cnt_t'(1));
  assign d_last     = (d_cnt_q == d_last_idx);
  assign d_fire     = bus.auto_out_d_valid & bus.auto_out_d_ready;

  // Non-final beats are always absorbed; the final beat is a combinational pass-through.
  assign bus.auto_in_d_valid       = bus.auto_out_d_valid & d_last;
  assign bus.auto_out_d_ready      = d_last ? bus.auto_in_d_ready : 1'b1;
  assign bus.auto_in_d_bits_opcode = d_hdr.opcode;
  assign bus.auto_in_d_bits_param  = d_hdr.param;
  assign bus.auto_in_d_bits_size   = d_hdr.size;
  assign bus.auto_in_d_bits_source = d_hdr.source;
  assign bus.auto_in_d_bits_sink   = d_hdr.sink;
  assign bus.auto_in_d_bits_denied  = d_denied_q  | bus.auto_out_d_bits_denied;
  assign bus.auto_in_d_bits_corrupt = d_corrupt_q | bus.auto_out_d_bits_corrupt;

  // Beat counts are powers of two, so wide lane gi replicates gathered lane (gi mod beats).
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_d_lanes
      assign d_sel[gi] = idx_t'(gi) & d_last_idx;
      assign bus.auto_in_d_bits_data[gi*LANE_W +: LANE_W] =
          (d_sel[gi] == d_last_idx) ? bus.auto_out_d_bits_data : d_buf_q[d_sel[gi]];
    end
  endgenerate

  always_comb begin
    d_cnt_d     = d_cnt_q;
    d_denied_d  = d_denied_q;
    d_corrupt_d = d_corrupt_q;
    d_store     = 1'b0;
    if (d_fire) begin
      if (d_last) begin
        d_cnt_d     = '0;
        d_denied_d  = 1'b0;
        d_corrupt_d = 1'b0;
      end else begin
        d_cnt_d     = d_cnt_q + idx_t'(1);
        d_denied_d  = d_denied_q  | bus.auto_out_d_bits_denied;
        d_corrupt_d = d_corrupt_q | bus.auto_out_d_bits_corrupt;
        d_store     = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a_idx_q     <= '0;
      d_cnt_q     <= '0;
      d_denied_q  <= 1'b0;
      d_corrupt_q <= 1'b0;
      for (int i = 0; i < RATIO; i++) d_buf_q[i] <= '0;
    end else begin
      a_idx_q     <= a_idx_d;
      d_cnt_q     <= d_cnt_d;
      d_denied_q  <= d_denied_d;
      d_corrupt_q <= d_corrupt_d;
      if (d_store) d_buf_q[d_cnt_q] <= bus.auto_out_d_bits_data;
    end
  end
endmodule
